// File: rtl/fix_c_mult_arb.sv
// Round-robin front end for one shared pipelined complex multiplier: grants one
// requester per cycle, tags each issue, and collects products in a credit-guarded FIFO.
module fix_c_mult_arb #(
  parameter int NUM_REQ    = 4,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SHW        = $clog2(2*IN_WIDTH+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_opa_R,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_opa_I,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_opb_R,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_opb_I,
  input  logic [NUM_REQ-1:0]            req_conj,
  input  logic [NUM_REQ*SHW-1:0]        req_shift,
  output logic [IN_WIDTH-1:0]           mc_opa_R,
  output logic [IN_WIDTH-1:0]           mc_opa_I,
  output logic [IN_WIDTH-1:0]           mc_opb_R,
  output logic [IN_WIDTH-1:0]           mc_opb_I,
  output logic                          mc_arith_mode_R,
  output logic                          mc_arith_mode_I,
  output logic                          mc_flip,
  output logic [SHW-1:0]                mc_shift_amount,
  input  logic [OUT_WIDTH-1:0]          mc_out_R,
  input  logic [OUT_WIDTH-1:0]          mc_out_I,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [OUT_WIDTH-1:0]          resp_R,
  output logic [OUT_WIDTH-1:0]          resp_I,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [IDW-1:0]       last;
  logic [IDW-1:0]       win_idx;
  logic                 win_found;
  logic                 grant;
  logic                 pop;
  logic                 push;
  logic [CW-1:0]        credits;
  logic [LATENCY:0]     tag_valid;
  logic [IDW-1:0]       tag_id [LATENCY+1];
  logic [IDW-1:0]       fifo_id [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] fifo_R [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] fifo_I [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  // Round-robin search starting just after the previous winner
  always_comb begin : arb_comb
    int  cand;
    logic hit;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    hit       = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand      = (int'(last) + i) % NUM_REQ;
      hit       = req_valid[cand[IDW-1:0]] && !win_found;
      win_idx   = hit ? cand[IDW-1:0] : win_idx;
      win_found = win_found || hit;
    end
  end

  assign grant     = win_found && (credits != CW'(0));
  assign req_ready = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : {NUM_REQ{1'b0}};

  assign resp_valid = (count != CW'(0));
  assign pop        = resp_valid && resp_ready;
  assign push       = tag_valid[LATENCY];
  assign resp_id    = resp_valid ? fifo_id[rd_ptr] : {IDW{1'b0}};
  assign resp_R     = resp_valid ? fifo_R[rd_ptr]  : {OUT_WIDTH{1'b0}};
  assign resp_I     = resp_valid ? fifo_I[rd_ptr]  : {OUT_WIDTH{1'b0}};
  assign busy       = (|tag_valid) || resp_valid;
  assign mc_flip    = 1'b0;

  // Pointer and credit bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= IDW'(NUM_REQ-1);
      credits <= CW'(FIFO_DEPTH);
    end else begin
      if (grant) last <= win_idx;
      case ({grant, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Operand registers feeding the multiplier; hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_opa_R        <= {IN_WIDTH{1'b0}};
      mc_opa_I        <= {IN_WIDTH{1'b0}};
      mc_opb_R        <= {IN_WIDTH{1'b0}};
      mc_opb_I        <= {IN_WIDTH{1'b0}};
      mc_arith_mode_R <= 1'b0;
      mc_arith_mode_I <= 1'b0;
      mc_shift_amount <= {SHW{1'b0}};
    end else if (grant) begin
      mc_opa_R        <= req_opa_R[win_idx*IN_WIDTH +: IN_WIDTH];
      mc_opa_I        <= req_opa_I[win_idx*IN_WIDTH +: IN_WIDTH];
      mc_opb_R        <= req_opb_R[win_idx*IN_WIDTH +: IN_WIDTH];
      mc_opb_I        <= req_opb_I[win_idx*IN_WIDTH +: IN_WIDTH];
      mc_arith_mode_R <= req_conj[win_idx];
      mc_arith_mode_I <= req_conj[win_idx];
      mc_shift_amount <= req_shift[win_idx*SHW +: SHW];
    end
  end

  // Tag pipe tracking which requester owns each product in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= {(LATENCY+1){1'b0}};
      for (int k = 0; k <= LATENCY; k++) tag_id[k] <= {IDW{1'b0}};
    end else begin
      tag_valid <= {tag_valid[LATENCY-1:0], grant};
      tag_id[0] <= win_idx;
      for (int k = 1; k <= LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // Response FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response FIFO storage; credits guarantee a free slot on every push
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= tag_id[LATENCY];
      fifo_R[wr_ptr]  <= mc_out_R;
      fifo_I[wr_ptr]  <= mc_out_I;
    end
  end

endmodule

// File: tb/tb_fix_c_mult_arb.sv
// Scoreboard bench for fix_c_mult_arb with a behavioural pipelined multiplier attached.
module tb_fix_c_mult_arb;

  localparam int N   = 4;
  localparam int IW  = 16;
  localparam int OW  = 16;
  localparam int LAT = 4;
  localparam int D   = 8;
  localparam int SHW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_opa_R, req_opa_I, req_opb_R, req_opb_I;
  logic [N-1:0]    req_conj;
  logic [N*SHW-1:0] req_shift;
  logic [IW-1:0]   mc_opa_R, mc_opa_I, mc_opb_R, mc_opb_I;
  logic            mc_arith_mode_R, mc_arith_mode_I, mc_flip;
  logic [SHW-1:0]  mc_shift_amount;
  logic [OW-1:0]   mc_out_R, mc_out_I;
  logic            resp_valid, resp_ready;
  logic [1:0]      resp_id;
  logic [OW-1:0]   resp_R, resp_I;
  logic            busy;

  fix_c_mult_arb #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LATENCY(LAT),
                   .FIFO_DEPTH(D), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opa_R(req_opa_R), .req_opa_I(req_opa_I), .req_opb_R(req_opb_R), .req_opb_I(req_opb_I),
    .req_conj(req_conj), .req_shift(req_shift),
    .mc_opa_R(mc_opa_R), .mc_opa_I(mc_opa_I), .mc_opb_R(mc_opb_R), .mc_opb_I(mc_opb_I),
    .mc_arith_mode_R(mc_arith_mode_R), .mc_arith_mode_I(mc_arith_mode_I), .mc_flip(mc_flip),
    .mc_shift_amount(mc_shift_amount), .mc_out_R(mc_out_R), .mc_out_I(mc_out_I),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_R(resp_R), .resp_I(resp_I), .busy(busy)
  );

  always #5 clk = ~clk;

  // Complex product, optionally conjugating b, arithmetic right shift, truncated
  function automatic logic [31:0] cmul(input logic [15:0] ar, input logic [15:0] ai,
                                       input logic [15:0] br, input logic [15:0] bi,
                                       input logic cj, input logic [5:0] sh);
    logic signed [33:0] xar, xai, xbr, xbi, pr, pi;
    xar = {{18{ar[15]}}, ar};
    xai = {{18{ai[15]}}, ai};
    xbr = {{18{br[15]}}, br};
    xbi = {{18{bi[15]}}, bi};
    if (cj) begin
      pr = xar * xbr + xai * xbi;
      pi = xai * xbr - xar * xbi;
    end else begin
      pr = xar * xbr - xai * xbi;
      pi = xar * xbi + xai * xbr;
    end
    pr = pr >>> sh;
    pi = pi >>> sh;
    return {pr[15:0], pi[15:0]};
  endfunction

  // Behavioural multiplier: LAT register stages after the mc_* inputs
  logic [31:0] mpipe [LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= cmul(mc_opa_R, mc_opa_I, mc_opb_R, mc_opb_I, mc_arith_mode_R, mc_shift_amount);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mc_out_R = mpipe[LAT-1][31:16];
  assign mc_out_I = mpipe[LAT-1][15:0];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] prod;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   last = N-1;
  int   grant_cnt = 0;
  logic mc_pend = 1'b0;
  logic [15:0] e_ar, e_ai, e_br, e_bi;
  logic        e_cj;
  logic [5:0]  e_sh;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      req_opa_R[k*IW +: IW] = 16'($urandom);
      req_opa_I[k*IW +: IW] = 16'($urandom);
      req_opb_R[k*IW +: IW] = 16'($urandom);
      req_opb_I[k*IW +: IW] = 16'($urandom);
      req_conj[k]           = 1'($urandom_range(0, 1));
      req_shift[k*SHW +: SHW] = 6'($urandom_range(0, 3));
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return after rise
  task automatic tick();
    logic       vis, found, elig;
    int         w, c;
    logic [N-1:0] exp_rr;
    exp_t       e;
    @(negedge clk);
    vis   = (q.size() > 0) && (q[0].rdy <= cyc);
    found = 1'b0;
    w     = 0;
    for (int i = 1; i <= N; i++) begin
      c = (last + i) % N;
      if (!found && req_valid[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    elig   = found && (q.size() < D);
    exp_rr = elig ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("resp_valid", 64'(resp_valid), 64'(vis));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    if (vis) begin
      chk("resp_id", 64'(resp_id), 64'(q[0].id));
      chk("resp_R", 64'(resp_R), 64'(q[0].prod[31:16]));
      chk("resp_I", 64'(resp_I), 64'(q[0].prod[15:0]));
    end
    if (mc_pend) begin
      chk("mc_ops", {mc_opa_R, mc_opa_I, mc_opb_R, mc_opb_I}, {e_ar, e_ai, e_br, e_bi});
      chk("mc_mode", {61'd0, mc_arith_mode_R, mc_arith_mode_I, mc_flip}, {61'd0, e_cj, e_cj, 1'b0});
      chk("mc_shift", 64'(mc_shift_amount), 64'(e_sh));
      mc_pend = 1'b0;
    end
    if (|(req_valid & req_ready)) grant_cnt++;
    if (vis && resp_ready) void'(q.pop_front());
    if (elig) begin
      e_ar = req_opa_R[w*IW +: IW];
      e_ai = req_opa_I[w*IW +: IW];
      e_br = req_opb_R[w*IW +: IW];
      e_bi = req_opb_I[w*IW +: IW];
      e_cj = req_conj[w];
      e_sh = req_shift[w*SHW +: SHW];
      e.id   = 2'(w);
      e.prod = cmul(e_ar, e_ai, e_br, e_bi, e_cj, e_sh);
      e.rdy  = cyc + LAT + 2;
      q.push_back(e);
      last    = w;
      mc_pend = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    repeat (LAT + D + 4) tick();
  endtask

  task automatic set_one(input int k, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi, input logic cj);
    req_opa_R[k*IW +: IW] = ar;
    req_opa_I[k*IW +: IW] = ai;
    req_opb_R[k*IW +: IW] = br;
    req_opb_I[k*IW +: IW] = bi;
    req_conj[k]           = cj;
    req_shift[k*SHW +: SHW] = 6'd0;
    req_valid             = 4'b0001 << k;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    req_opa_R  = '0; req_opa_I = '0; req_opb_R = '0; req_opb_I = '0;
    req_conj   = '0; req_shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mc", {mc_opa_R, mc_opa_I, mc_opb_R, mc_opb_I}, 64'd0);
    chk("rst_mc_misc", {55'd0, mc_arith_mode_R, mc_arith_mode_I, mc_flip, mc_shift_amount}, 64'd0);
    chk("rst_resp", {29'd0, resp_valid, resp_id, resp_R, resp_I}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    repeat (6) tick();

    // Single request from requester 2, then the conjugate path on requester 1
    set_one(2, 16'd2, 16'd3, 16'd4, 16'd5, 1'b0);
    tick();
    req_valid = 4'b0000;
    repeat (LAT + 3) tick();
    set_one(1, 16'd2, 16'd3, 16'd4, 16'd5, 1'b1);
    tick();
    req_valid = 4'b0000;
    repeat (LAT + 3) tick();

    // Fairness: all requesters continuously valid
    req_valid = 4'b1111;
    repeat (8) begin rand_ops(); tick(); end
    drain();

    // Credit exhaustion, then a single pop releases exactly one grant
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    grant_cnt  = 0;
    repeat (20) begin rand_ops(); tick(); end
    chk("exhaust_grants", 64'(grant_cnt), 64'd8);
    grant_cnt  = 0;
    resp_ready = 1'b1;
    rand_ops(); tick();
    resp_ready = 1'b0;
    repeat (5) begin rand_ops(); tick(); end
    chk("one_pop_grants", 64'(grant_cnt), 64'd1);
    drain();

    // Random traffic with random back-pressure
    repeat (100) begin
      rand_ops();
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with products both in flight and queued
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    repeat (5) begin rand_ops(); tick(); end
    req_valid = 4'b0000;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mc", 64'(mc_opa_R), 64'd0);
    q.delete();
    last    = N-1;
    mc_pend = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    repeat (4) begin rand_ops(); tick(); end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
